// File: rtl/retire_pkg.sv
// retire_pkg: shared types for the retire stage.
//   addr_t / gpreg_t  : XLEN-wide address and general-purpose register types
//   ex_code_t         : exception cause codes carried by the exec units
//   exec_result       : per-instruction result from the exec result mux
//   retire_entry      : one completed instruction offered to retire
//   retire_state_t    : retire control FSM states
//   mcause_of()       : exception code -> mcause value
package retire_pkg;

  localparam int XLEN = 32;
  localparam int EX_W = 4;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] gpreg_t;

  typedef enum logic [EX_W-1:0] {
    EX_INSTR_ADDR_MISALIGNED  = 4'd0,
    EX_INSTR_ACCESS_FAULT     = 4'd1,
    EX_ILLEGAL_INSTR          = 4'd2,
    EX_BREAKPOINT             = 4'd3,
    EX_LOAD_ADDR_MISALIGNED   = 4'd4,
    EX_LOAD_ACCESS_FAULT      = 4'd5,
    EX_STORE_ADDR_MISALIGNED  = 4'd6,
    EX_STORE_ACCESS_FAULT     = 4'd7,
    EX_ECALL_U                = 4'd8,
    EX_ECALL_M                = 4'd11
  } ex_code_t;

  typedef struct packed {
    logic [4:0] rd_idx;
    gpreg_t     rd_val;     // don't-care when rd_we=0 (may be X)
    logic       br_valid;
    addr_t      br_target;
    logic       ex_valid;
    ex_code_t   ex;
    gpreg_t     ex_tval;
    logic       ret_valid;
  } exec_result;

  typedef struct packed {
    addr_t      pc;
    logic       rd_we;
    exec_result res;
  } retire_entry;

  typedef enum logic {
    RETIRE_RUN,
    RETIRE_REDIRECT
  } retire_state_t;

  // Synchronous exceptions only: interrupt bit clear, code zero-extended.
  function automatic gpreg_t mcause_of(input ex_code_t ex);
    return {{(XLEN-EX_W){1'b0}}, ex};
  endfunction

endpackage

// File: rtl/retire_trap_regs.sv
// retire_trap_regs: mepc / mcause / mtval storage with a single write strobe.
//   clk, rst     : clock, synchronous active-high reset
//   we           : load all three registers this cycle
//   epc/cause/tval: values loaded on we
//   mepc/mcause/mtval: current register contents
module retire_trap_regs
  import retire_pkg::*;
#(
  parameter addr_t MEPC_RESET = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   we,
  input  addr_t  epc,
  input  gpreg_t cause,
  input  gpreg_t tval,
  output addr_t  mepc,
  output gpreg_t mcause,
  output gpreg_t mtval
);

  addr_t  mepc_q,   mepc_d;
  gpreg_t mcause_q, mcause_d;
  gpreg_t mtval_q,  mtval_d;

  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    if (we) begin
      mepc_d   = epc;
      mcause_d = cause;
      mtval_d  = tval;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_q   <= MEPC_RESET;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
    end
  end

  assign mepc   = mepc_q;
  assign mcause = mcause_q;
  assign mtval  = mtval_q;

endmodule

// File: rtl/retire.sv
// retire: consumer end of the execution-result stream.
//   clk, rst                      : clock, synchronous active-high reset
//   entry_valid/entry_ready/entry : completed-instruction input (one per cycle)
//   mtvec                         : trap vector base (direct mode, [1:0] ignored)
//   rf_we/rf_waddr/rf_wdata       : registered register-file write port
//   redirect_valid/ready/target   : fetch redirect, held stable until accepted
//   flush                         : one-cycle pulse, discard younger work
//   mepc/mcause/mtval             : trap register view
//   instret                       : retired-instruction counter (wraps)
module retire
  import retire_pkg::*;
#(
  parameter int    INSTRET_WIDTH = 64,
  parameter addr_t MEPC_RESET    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     entry_valid,
  output logic                     entry_ready,
  input  retire_entry              entry,
  input  addr_t                    mtvec,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output gpreg_t                   rf_wdata,
  output logic                     redirect_valid,
  input  logic                     redirect_ready,
  output addr_t                    redirect_target,
  output logic                     flush,
  output addr_t                    mepc,
  output gpreg_t                   mcause,
  output gpreg_t                   mtval,
  output logic [INSTRET_WIDTH-1:0] instret
);

  retire_state_t state_q, state_d;

  addr_t                    target_q, target_d;
  logic                     flush_q, flush_d;
  logic                     rf_we_q, rf_we_d;
  logic [4:0]               rf_waddr_q, rf_waddr_d;
  gpreg_t                   rf_wdata_q, rf_wdata_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  logic fire;
  logic is_ex, is_ret, is_br;
  logic redirects;
  logic wr_ok;
  logic retired;
  logic trap_we;

  // Direct-mode vector: low two bits are mode bits and never reach the PC.
  logic unused_mtvec_lsb;
  assign unused_mtvec_lsb = ^mtvec[1:0];

  // Entry decode. Exception outranks MRET, which outranks branch/jump.
  always_comb begin
    fire      = entry_valid && entry_ready;
    is_ex     = entry.res.ex_valid;
    is_ret    = !is_ex && entry.res.ret_valid;
    is_br     = !is_ex && !is_ret && entry.res.br_valid;
    redirects = fire && (is_ex || is_ret || is_br);
    // Branch/jump still writes its link register; trap and MRET never do.
    wr_ok     = fire && !is_ex && !is_ret && entry.rd_we && (entry.res.rd_idx != 5'd0);
    retired   = fire && !is_ex;
    trap_we   = fire && is_ex;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= RETIRE_RUN;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RETIRE_RUN:      if (redirects)      state_d = RETIRE_REDIRECT;
      RETIRE_REDIRECT: if (redirect_ready) state_d = RETIRE_RUN;
      default:                             state_d = RETIRE_RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    entry_ready    = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      RETIRE_RUN:      entry_ready    = 1'b1;
      RETIRE_REDIRECT: redirect_valid = 1'b1;
      default:         entry_ready    = 1'b0;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    // Target only changes on an accepted entry, and entries are only
    // accepted in RUN, so it is stable for the whole REDIRECT stall.
    target_d = target_q;
    if (fire) begin
      if (is_ex)       target_d = {mtvec[XLEN-1:2], 2'b00};
      else if (is_ret) target_d = mepc;  // trap before MRET has already landed
      else if (is_br)  target_d = entry.res.br_target;
    end

    flush_d    = redirects;
    rf_we_d    = wr_ok;
    // Gate address and data so a branch's X rd_val never reaches the port.
    rf_waddr_d = wr_ok ? entry.res.rd_idx : 5'd0;
    rf_wdata_d = wr_ok ? entry.res.rd_val : '0;
    instret_d  = instret_q + {{(INSTRET_WIDTH-1){1'b0}}, retired};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q   <= '0;
      flush_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      instret_q  <= '0;
    end else begin
      target_q   <= target_d;
      flush_q    <= flush_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      instret_q  <= instret_d;
    end
  end

  retire_trap_regs #(
    .MEPC_RESET(MEPC_RESET)
  ) u_trap_regs (
    .clk    (clk),
    .rst    (rst),
    .we     (trap_we),
    .epc    (entry.pc),
    .cause  (mcause_of(entry.res.ex)),
    .tval   (entry.res.ex_tval),
    .mepc   (mepc),
    .mcause (mcause),
    .mtval  (mtval)
  );

  assign redirect_target = target_q;
  assign flush           = flush_q;
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign instret         = instret_q;

endmodule

// File: doc/retire.md
Name: retire

Overview:
- Consumer end of the execution-result stream.
- Accepts one completed instruction per cycle from the exec units (pcrel, alu, lsu mux). Commits its register write, resolves control flow (branch/jump, exception, MRET) into a fetch redirect, and maintains the trap registers mepc/mcause/mtval plus an instret counter.
- Sits between the exec result mux and the register file / fetch unit.

Parameters:
INSTRET_WIDTH, 64, width of retired-instruction counter
MEPC_RESET, 0, reset value of mepc

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
entry  decoupled.in  retire_entry  pc, rd_we, exec_result {rd_idx, rd_val, br_valid, br_target, ex_valid, ex, ex_tval, ret_valid}
mtvec  input  addr  trap vector (direct mode; bits[1:0] ignored)
rf_we  output  1  register-file write enable
rf_waddr  output  5  write index
rf_wdata  output  gpreg  write data
redirect  decoupled.out  addr  fetch redirect target
flush  output  1  one-cycle pulse: discard all younger in-flight work
mepc, mcause, mtval  output  addr/gpreg/gpreg  trap registers (read-only view)
instret  output  INSTRET_WIDTH  retired count

Behaviour:
- Clock is clk; reset is synchronous, active-high on rst.
- Reset (any state, including mid-redirect):
  - state=RUN; redirect.valid=0, flush=0, rf_we=0.
  - mepc=MEPC_RESET, mcause=0, mtval=0, instret=0.
  - A pending redirect is dropped.
- States:
  - RUN: entry.ready=1.
  - REDIRECT: entry.ready=0; redirect.valid=1, holding a stable target until redirect.ready.
- Transitions:
  - RUN -> REDIRECT on entry fire with ex_valid|ret_valid|br_valid.
  - REDIRECT -> RUN on redirect fire (same edge).
- Priority on a fired entry: ex_valid > ret_valid > br_valid > plain.
  - ex_valid: no rf write, no instret increment. mepc<=pc, mcause<={0, zero-extended ex}, mtval<=ex_tval. Target={mtvec[XLEN-1:2],2'b00}.
  - ret_valid: target=current mepc; instret+1; no rf write.
  - br_valid: target=br_target; rf write if rd_we && rd_idx!=0 (JAL link); instret+1.
  - plain: rf write if rd_we && rd_idx!=0; instret+1; stay RUN.
- Latency:
  - rf_we/rf_waddr/rf_wdata are registered, valid exactly one cycle after fire. rf_we=0 otherwise. Writes to x0 are suppressed.
  - redirect.valid and flush assert in the cycle after fire; flush lasts exactly one cycle even if redirect stalls.
- Back-to-back plain entries sustain 1/cycle. After a redirecting entry, no entry is accepted until the cycle after redirect fire.
- ex_valid with ret_valid or br_valid also set: the exception wins; the other flags are ignored.
- mepc written and MRET in the same cycle cannot occur (one entry per cycle). An MRET immediately following a trap reads the updated mepc.
- instret wraps modulo 2^INSTRET_WIDTH.
- rd_val is don't-care when rd_we=0 (branches carry X). X must not propagate to rf_wdata when rf_we=0; drive 0.

Decomposition:
- Package (types.sv):
  - retire_entry struct {addr pc; logic rd_we; exec_result res;}
  - retire_state_t enum {RETIRE_RUN, RETIRE_REDIRECT}
  - mcause encoding helper function (ex code -> gpreg)
- Sub-module: retire_trap_regs holds mepc/mcause/mtval with a single write strobe. The rest stays in retire.

Test Plan:
- Plain ALU entry rd_we=1, rd_idx=5, rd_val=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, instret=1, no redirect/flush; rd_idx=0 -> rf_we=0, instret still increments.
- JAL entry pc=0x100, br_valid=1, br_target=0x200, rd_idx=1, rd_val=0x104 -> rf write x1=0x104, redirect.valid=1 target=0x200, flush one cycle; hold redirect.ready=0 for 3 cycles -> entry.ready=0 and target stable throughout; ready=1 -> RUN next cycle.
- Misaligned branch entry pc=0x80, ex_valid=1, ex=EX_INSTR_ADDR_MISALIGNED, ex_tval=0x86, br_valid=1, mtvec=0x1003 -> mepc=0x80, mcause=0, mtval=0x86, redirect target=0x1000, no rf write, instret unchanged.
- Trap followed immediately by an MRET entry -> redirect target equals the newly written mepc (0x80).
- Conditional branch not taken (br_valid=0, rd_we=0, rd_val=X) -> no redirect, rf_we=0, rf_wdata=0, instret+1; 10 back-to-back plain entries -> 10 retires in 10 cycles.
- Assert rst while in REDIRECT with redirect.ready=0 -> next cycle redirect.valid=0, state RUN, all trap regs and instret at reset values.
